// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR streaming front end.
package fir_pkg;

    localparam int unsigned FIR_DATA_WIDTH = 32;
    localparam int unsigned FIR_LEN_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } framer_state_t;

    typedef struct packed {
        logic                      last;
        logic [FIR_DATA_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// Registered single-clock FIFO; head word is presented combinationally on rdata.
module axis_sync_fifo #(
    parameter int unsigned pWIDTH = 33,
    parameter int unsigned pDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [pWIDTH-1:0]         wdata,
    input  logic                      pop,
    output logic [pWIDTH-1:0]         rdata,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(pDEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(pDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(pDEPTH);

    logic [pWIDTH-1:0] r_mem [pDEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (r_count == CNT_FULL);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Zero when empty so a stale slot never shows on the data lines.
    assign rdata = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/axis_tlast_framer.sv
// Frames a raw AXI-Stream into cfg_len-sample packets with tlast for the FIR slave port.
module axis_tlast_framer
    import fir_pkg::*;
#(
    parameter int unsigned pDATA_WIDTH = FIR_DATA_WIDTH,
    parameter int unsigned pFIFO_DEPTH = 4,
    parameter int unsigned pLEN_WIDTH  = FIR_LEN_WIDTH
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic [pLEN_WIDTH-1:0]  cfg_len,
    input  logic                   cfg_start,
    output logic                   busy,
    output logic                   done,
    input  logic                   in_tvalid,
    input  logic [pDATA_WIDTH-1:0] in_tdata,
    output logic                   in_tready,
    output logic                   ss_tvalid,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   ss_tready
);

    localparam int unsigned ENTRY_W = pDATA_WIDTH + 1;
    localparam int unsigned CNT_W   = $clog2(pFIFO_DEPTH) + 1;
    localparam logic [pLEN_WIDTH-1:0] LEN_ONE = {{(pLEN_WIDTH-1){1'b0}}, 1'b1};

    framer_state_t          r_state;
    framer_state_t          w_state_nxt;
    logic [pLEN_WIDTH-1:0]  r_len_q;
    logic [pLEN_WIDTH-1:0]  r_in_cnt;
    logic [pLEN_WIDTH-1:0]  r_out_cnt;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_last_in;
    logic                   w_accept_start;
    logic [CNT_W-1:0]       w_fifo_count;
    logic [ENTRY_W-1:0]     w_head;

    assign ss_tvalid      = !w_empty;
    assign ss_tlast       = w_head[pDATA_WIDTH];
    assign ss_tdata       = w_head[pDATA_WIDTH-1:0];
    assign w_pop          = !w_empty && ss_tready;
    assign w_push         = in_tvalid && in_tready;
    assign w_last_in      = (r_in_cnt == r_len_q - LEN_ONE);
    assign w_accept_start = (r_state == IDLE) && cfg_start && (cfg_len != '0);

    axis_sync_fifo #(
        .pWIDTH (ENTRY_W),
        .pDEPTH (pFIFO_DEPTH)
    ) u_fifo (
        .clk   (axis_clk),
        .rst_n (axis_rst_n),
        .push  (w_push),
        .wdata ({w_last_in, in_tdata}),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_fifo_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        in_tready   = 1'b0;
        done        = 1'b0;
        busy        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_len != '0) begin
                        w_state_nxt = FILL;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            FILL: begin
                busy      = 1'b1;
                in_tready = !w_full || w_pop;
                if (in_tvalid && in_tready && w_last_in) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (w_pop && ss_tlast) begin
                    done        = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state   <= IDLE;
            r_len_q   <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept_start) begin
                r_len_q   <= cfg_len;
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_in_cnt <= r_in_cnt + LEN_ONE;
                end
                if (w_pop) begin
                    r_out_cnt <= r_out_cnt + LEN_ONE;
                end
            end
        end
    end

    // The tlast entry can only be pushed on the transition into DRAIN, so it pops there.
    a_tlast_in_drain: assert property (@(posedge axis_clk) disable iff (!axis_rst_n)
        (w_pop && ss_tlast) |-> (r_state == DRAIN));

    a_tlast_count: assert property (@(posedge axis_clk) disable iff (!axis_rst_n)
        (w_pop && ss_tlast) |-> (r_out_cnt == r_len_q - LEN_ONE));

    a_fifo_bound: assert property (@(posedge axis_clk) disable iff (!axis_rst_n)
        w_fifo_count <= CNT_W'(pFIFO_DEPTH));

endmodule

// File: tb/tb_axis_tlast_framer.sv
// Directed bench for axis_tlast_framer: frames, stalls, zero length, restart, random handshakes, reset.
`timescale 1ns/1ps

`define CHK(SUB, OBS, EXP) \
    begin \
        n_vec++; \
        assert ((OBS) === (EXP)) else begin \
            n_fail++; \
            $error("FAIL %s.%s observed=%0h expected=%0h", cur, SUB, (OBS), (EXP)); \
        end \
    end

module tb_axis_tlast_framer;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic          cfg_start = 1'b0;
    logic          busy;
    logic          done;
    logic          in_tvalid = 1'b0;
    logic [DW-1:0] in_tdata = '0;
    logic          in_tready;
    logic          ss_tvalid;
    logic [DW-1:0] ss_tdata;
    logic          ss_tlast;
    logic          ss_tready = 1'b0;

    always #5 clk = ~clk;

    axis_tlast_framer #(
        .pDATA_WIDTH (DW),
        .pFIFO_DEPTH (4),
        .pLEN_WIDTH  (LW)
    ) dut (
        .axis_clk   (clk),
        .axis_rst_n (rst_n),
        .cfg_len    (cfg_len),
        .cfg_start  (cfg_start),
        .busy       (busy),
        .done       (done),
        .in_tvalid  (in_tvalid),
        .in_tdata   (in_tdata),
        .in_tready  (in_tready),
        .ss_tvalid  (ss_tvalid),
        .ss_tdata   (ss_tdata),
        .ss_tlast   (ss_tlast),
        .ss_tready  (ss_tready)
    );

    int      n_vec = 0;
    int      n_fail = 0;
    string   cur = "";

    logic [DW-1:0] obs_data[$];
    logic          obs_last[$];
    int            done_cnt;
    int            done_on_tlast;
    int            in_beats;
    int            drop_err;
    int            stab_err;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    bit            timed_out;
    int            stall_beats;
    logic          stall_rdy;
    logic          post_rdy;

    // Inputs change #1 after posedge, so negedge sees what the next posedge will act on.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !ss_tvalid) drop_err++;
            if (prev_stall && (ss_tdata !== prev_data || ss_tlast !== prev_last)) stab_err++;
            if (ss_tvalid && ss_tready) begin
                obs_data.push_back(ss_tdata);
                obs_last.push_back(ss_tlast);
                if (done && ss_tlast) done_on_tlast++;
            end
            if (done) done_cnt++;
            if (in_tvalid && in_tready) in_beats++;
            prev_stall = ss_tvalid && !ss_tready;
            prev_data  = ss_tdata;
            prev_last  = ss_tlast;
        end
    end

    task automatic clear_mon();
        obs_data.delete();
        obs_last.delete();
        done_cnt      = 0;
        done_on_tlast = 0;
        in_beats      = 0;
        drop_err      = 0;
        stab_err      = 0;
        prev_stall    = 1'b0;
    endtask

    task automatic run_frame(input int len, input int vpct, input int rpct,
                             input int stall, input int restart_at, input logic [DW-1:0] base);
        int sent;
        int cyc;
        bit seen;
        sent = 0;
        cyc  = 0;
        seen = 1'b0;
        clear_mon();
        cfg_len   = len;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        while (!seen && cyc < 4000) begin
            if (cyc == stall) begin
                stall_beats = in_beats;
                stall_rdy   = in_tready;
            end
            cfg_start = (cyc == restart_at);
            cfg_len   = (cyc == restart_at) ? 32'd3 : 32'hDEAD_BEEF;
            in_tvalid = int'($urandom_range(100, 1)) <= vpct;
            ss_tready = (cyc >= stall) && (int'($urandom_range(100, 1)) <= rpct);
            in_tdata  = base + sent;
            @(negedge clk);
            if (cyc == stall) post_rdy = in_tready;
            if (in_tvalid && in_tready) sent++;
            if (done) seen = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        timed_out = !seen;
        cfg_start = 1'b0;
        in_tvalid = 1'b1;
        ss_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_tvalid = 1'b0;
        ss_tready = 1'b0;
    endtask

    task automatic check_frame(input int len, input logic [DW-1:0] base);
        `CHK("timeout", timed_out, 1'b0)
        `CHK("beats", obs_data.size(), len)
        for (int k = 0; k < len && k < obs_data.size(); k++) begin
            `CHK("data", obs_data[k], base + k)
            `CHK("tlast", obs_last[k], (k == len - 1))
        end
        `CHK("done_cnt", done_cnt, 1)
        `CHK("done_on_tlast", done_on_tlast, 1)
        `CHK("in_beats", in_beats, len)
        `CHK("valid_drop", drop_err, 0)
        `CHK("stall_stable", stab_err, 0)
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_mon();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        cur = "reset";
        @(negedge clk);
        `CHK("busy", busy, 1'b0)
        `CHK("done", done, 1'b0)
        `CHK("in_tready", in_tready, 1'b0)
        `CHK("ss_tvalid", ss_tvalid, 1'b0)
        `CHK("ss_tlast", ss_tlast, 1'b0)
        `CHK("ss_tdata", ss_tdata, 32'h0)
        @(posedge clk); #1;

        cur = "len600";
        run_frame(600, 100, 100, 0, -1, 32'h1000_0000);
        check_frame(600, 32'h1000_0000);

        cur = "stall5";
        run_frame(5, 100, 100, 10, -1, 32'h2000_0000);
        `CHK("beats_in_stall", stall_beats, 4)
        `CHK("tready_in_stall", stall_rdy, 1'b0)
        `CHK("tready_full_pop", post_rdy, 1'b1)
        check_frame(5, 32'h2000_0000);

        cur = "len0";
        cfg_len   = '0;
        cfg_start = 1'b1;
        @(negedge clk);
        `CHK("done", done, 1'b1)
        `CHK("busy", busy, 1'b0)
        `CHK("ss_tvalid", ss_tvalid, 1'b0)
        `CHK("in_tready", in_tready, 1'b0)
        @(posedge clk); #1;
        cfg_start = 1'b0;
        in_tvalid = 1'b1;
        @(negedge clk);
        `CHK("done_after", done, 1'b0)
        `CHK("busy_after", busy, 1'b0)
        `CHK("in_tready_after", in_tready, 1'b0)
        `CHK("ss_tvalid_after", ss_tvalid, 1'b0)
        @(posedge clk); #1;
        in_tvalid = 1'b0;

        cur = "restart";
        run_frame(8, 100, 100, 0, 3, 32'h3000_0000);
        check_frame(8, 32'h3000_0000);

        cur = "random11";
        run_frame(11, 50, 50, 0, -1, 32'h4000_0000);
        check_frame(11, 32'h4000_0000);

        cur = "reset_mid";
        cfg_len   = 32'd8;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        in_tvalid = 1'b1;
        ss_tready = 1'b0;
        in_tdata  = 32'h5000_0000;
        @(negedge clk);
        `CHK("in_tready", in_tready, 1'b1)
        `CHK("ss_tvalid_lat0", ss_tvalid, 1'b0)
        @(posedge clk); #1;
        in_tdata = 32'h5000_0001;
        @(negedge clk);
        `CHK("ss_tvalid_lat1", ss_tvalid, 1'b1)
        `CHK("ss_tdata_lat1", ss_tdata, 32'h5000_0000)
        @(posedge clk); #1;
        in_tdata = 32'h5000_0002;
        @(posedge clk); #1;
        rst_n     = 1'b0;
        in_tvalid = 1'b0;
        #1;
        `CHK("busy", busy, 1'b0)
        `CHK("done", done, 1'b0)
        `CHK("in_tready", in_tready, 1'b0)
        `CHK("ss_tvalid", ss_tvalid, 1'b0)
        `CHK("ss_tlast", ss_tlast, 1'b0)
        `CHK("ss_tdata", ss_tdata, 32'h0)
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        cur = "after_reset";
        run_frame(2, 100, 100, 0, -1, 32'h6000_0000);
        check_frame(2, 32'h6000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_tlast_framer.md
Name: axis_tlast_framer

Overview:
- Upstream feeder for the FIR data path. It accepts a raw AXI-Stream sample stream that carries no tlast, buffers it in a small FIFO, and drives the FIR ss_* slave port.
- It asserts tlast exactly on the cfg_len-th sample of a frame, so the FIR's ap_done and sm_tlast line up with data_length.
- It stops accepting input once the frame is complete, and reports busy and done to the control logic.

Parameters:
pDATA_WIDTH, 32, sample width in bits
pFIFO_DEPTH, 4, FIFO entries; power of two, minimum 2
pLEN_WIDTH, 32, width of the frame-length register and sample counters

Ports:
axis_clk  in  1  clock
axis_rst_n  in  1  reset; asynchronous, active-low
cfg_len  in  pLEN_WIDTH  samples per frame; sampled on cfg_start
cfg_start  in  1  one-cycle pulse that begins a frame
busy  out  1  high from accepted start until the last output beat
done  out  1  one-cycle pulse on the last output handshake
in_tvalid  in  1  raw sample valid
in_tdata  in  pDATA_WIDTH  raw sample
in_tready  out  1  framer can accept a raw sample
ss_tvalid  out  1  to FIR ss_tvalid
ss_tdata  out  pDATA_WIDTH  to FIR ss_tdata
ss_tlast  out  1  to FIR ss_tlast
ss_tready  in  1  from FIR ss_tready

Behaviour:
- Reset (async assert, sync release): state=IDLE; FIFO empty; counters=0.
  - busy=0, done=0, in_tready=0, ss_tvalid=0, ss_tlast=0, ss_tdata=0.
- A reset asserted mid-frame discards the FIFO contents and the partial frame. There is no resume.
- Handshakes:
  - Input beat = in_tvalid & in_tready.
  - Output beat = ss_tvalid & ss_tready.
  - ss_tdata and ss_tlast hold stable while ss_tvalid=1 and ss_tready=0.
  - ss_tvalid never drops without a handshake.
- FIFO:
  - Each entry is {last, data}, registered.
  - Head drives ss_tdata and ss_tlast directly; ss_tvalid = !empty.
  - Simultaneous push and pop while full is allowed: a full FIFO with ss_tready=1 keeps in_tready=1.
  - Pointers wrap modulo pFIFO_DEPTH; a count register distinguishes full from empty.
- State machine:
  - IDLE:
    - cfg_start with cfg_len!=0 -> latch len_q=cfg_len, in_cnt=0, out_cnt=0, go to FILL.
    - cfg_start with cfg_len==0 -> done=1 for one cycle, stay in IDLE, no beats.
  - FILL:
    - in_tready = !full | pop.
    - Each input beat pushes {in_cnt==len_q-1, in_tdata} and increments in_cnt.
    - On the beat with in_cnt==len_q-1, go to DRAIN; in_tready is 0 from the next cycle.
  - DRAIN:
    - in_tready=0; the FIFO empties.
    - On the output beat with ss_tlast=1: done=1 that cycle, go to IDLE.
- busy=1 in FILL and DRAIN. A cfg_start while busy is ignored, and cfg_len changes mid-frame have no effect.
- A pop in FILL may coincide with a push. The tlast entry may be popped in FILL only if its push happened earlier, which is impossible because the push moves the state to DRAIN; so done is only ever produced from DRAIN.
- Counters:
  - Unsigned, pLEN_WIDTH wide, no wrap; the maximum frame is 2^pLEN_WIDTH-1.
  - out_cnt counts output beats and exists for assertions only.
- Latency: a sample presented to an empty FIFO appears on ss_tvalid one cycle after its input beat.
- Throughput: one sample per cycle when ss_tready is held at 1.
- No combinational path from in_tvalid to ss_tvalid. in_tready depends combinationally on ss_tready only through the pop term.

Decomposition:
- Shared package fir_pkg: pDATA_WIDTH default, pLEN_WIDTH default, the state encoding enum {IDLE, FILL, DRAIN}, and the FIFO entry struct {last, data}.
- One sub-module: axis_sync_fifo (parameterised width and depth; push/pop/full/empty/count). The framer owns the state machine and the counters.

Test Plan:
- Frame of 600 samples, ss_tready=1:
  - Exactly 600 output beats in order, ss_tlast only on beat 599.
  - done pulses once, in the cycle of beat 599.
  - in_tready is 0 after the 600th input beat even though in_tvalid stays 1.
- cfg_len=5, ss_tready held 0 for 10 cycles, then 1:
  - in_tready drops after 4 accepted samples.
  - ss_tdata is stable throughout the stall.
  - All 5 samples drain with tlast on the 5th.
- cfg_len=0 with cfg_start:
  - done=1 for one cycle, busy stays 0.
  - No ss_tvalid, in_tready stays 0.
- cfg_start pulsed again mid-frame with cfg_len=3 while len_q=8:
  - Ignored; tlast still lands on beat 8.
- Random in_tvalid and ss_tready (50% each), cfg_len=11:
  - Output data matches input order, 11 beats, one tlast.
  - No ss_tvalid drop without a handshake.
- axis_rst_n pulsed low after 3 of 8 samples, then a new start with cfg_len=2:
  - Outputs return to their reset values immediately.
  - The next frame emits 2 beats with tlast on the 2nd; no stale data appears.
